// File: rtl/zephyr_seq_alu.sv
// zephyr_seq_alu: add/sub in one step, shift-add mul and restoring div over WIDTH steps.
// Optional: define ZEPHYR_ALU_FLAGS_EN to add the FLAG_Z / FLAG_C outputs.
module zephyr_seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [1:0]       OPCODE,
   input  logic [WIDTH-1:0] DATA_A,
   input  logic [WIDTH-1:0] DATA_B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             DIV_BY_ZERO
`ifdef ZEPHYR_ALU_FLAGS_EN
   ,
   output logic             FLAG_Z,
   output logic             FLAG_C
`endif
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             dbz_q, dbz_d;

   logic             accept;
   logic             quick;
   logic             last_iter;
   logic             is_mul;
   logic             commit;
   logic [WIDTH-1:0] res;
   logic             res_dbz;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH:0]   rem_sh;
   logic             div_ok;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] div_q;

   // A new request is taken when idle or in the DONE cycle
   assign accept    = START && (state_q != S_EXEC);
   assign quick     = (OPCODE == OP_ADD) || (OPCODE == OP_SUB) ||
                      ((OPCODE == OP_DIV) && (DATA_B == '0));
   assign last_iter = (state_q == S_EXEC) && (cnt_q == CW'(WIDTH - 1));
   assign is_mul    = (op_q == OP_MUL);

   // Right-shifting multiplier: {hi,lo} ends as the full product
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
   assign mul_hi  = mul_sum[WIDTH:1];
   assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

   // Restoring divider: hi holds the partial remainder, lo the quotient
   assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
   assign div_ok  = rem_sh >= {1'b0, opb_q};
   assign div_rem = div_ok ? WIDTH'(rem_sh - {1'b0, opb_q})
                           : rem_sh[WIDTH-1:0];
   assign div_q   = {lo_q[WIDTH-2:0], div_ok};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_FIN: begin
            if (accept) begin
               state_d = quick ? S_FIN : S_EXEC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            state_d = last_iter ? S_FIN : S_EXEC;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      BUSY        = (state_q != S_IDLE);
      DONE        = (state_q == S_FIN);
      DATA_OUT    = out_q;
      DIV_BY_ZERO = dbz_q;
   end

   always_comb begin
      op_d    = op_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      dbz_d   = dbz_q;
      res     = '0;
      res_dbz = 1'b0;
      commit  = 1'b0;
      if (accept) begin
         op_d   = OPCODE;
         opb_d  = DATA_B;
         hi_d   = '0;
         lo_d   = DATA_A;
         cnt_d  = '0;
         commit = quick;
         unique case (OPCODE)
            OP_ADD: res = DATA_A + DATA_B;
            OP_SUB: res = DATA_A - DATA_B;
            default: begin
               res     = '1;
               res_dbz = 1'b1;
            end
         endcase
      end else if (state_q == S_EXEC) begin
         cnt_d  = cnt_q + CW'(1);
         hi_d   = is_mul ? mul_hi : div_rem;
         lo_d   = is_mul ? mul_lo : div_q;
         commit = last_iter;
         res    = is_mul ? mul_lo : div_q;
      end
      if (commit) begin
         out_d = res;
         dbz_d = res_dbz;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         op_q  <= OP_ADD;
         opb_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
         out_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         op_q  <= op_d;
         opb_q <= opb_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
         out_q <= out_d;
         dbz_q <= dbz_d;
      end
   end

`ifdef ZEPHYR_ALU_FLAGS_EN
   logic fz_q, fz_d;
   logic fc_q, fc_d;
   logic res_c;

   always_comb begin
      fz_d  = fz_q;
      fc_d  = fc_q;
      res_c = 1'b0;
      if (accept) begin
         unique case (OPCODE)
            OP_ADD:  res_c = (res < DATA_A);
            OP_SUB:  res_c = (DATA_A < DATA_B);
            default: res_c = 1'b0;
         endcase
      end else begin
         res_c = is_mul && (mul_hi != '0);
      end
      if (commit) begin
         fz_d = (res == '0);
         fc_d = res_c;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         fz_q <= 1'b0;
         fc_q <= 1'b0;
      end else begin
         fz_q <= fz_d;
         fc_q <= fc_d;
      end
   end

   assign FLAG_Z = fz_q;
   assign FLAG_C = fc_q;
`endif

endmodule

// File: tb/tb_zephyr_seq_alu.sv
// Bench for zephyr_seq_alu: directed ops against a latency/result model.
// Flag checks are active when ZEPHYR_ALU_FLAGS_EN is defined.
module tb_zephyr_seq_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   opcode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] dout;
   logic         dbz;
`ifdef ZEPHYR_ALU_FLAGS_EN
   logic         fz;
   logic         fc;
`endif

   int checks = 0;
   int errors = 0;
   int n_done = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   zephyr_seq_alu #(.WIDTH(W)) dut (
      .CLK(clk),
      .RST(rst),
      .START(start),
      .OPCODE(opcode),
      .DATA_A(a),
      .DATA_B(b),
      .BUSY(busy),
      .DONE(done),
      .DATA_OUT(dout),
      .DIV_BY_ZERO(dbz)
`ifdef ZEPHYR_ALU_FLAGS_EN
      ,
      .FLAG_Z(fz),
      .FLAG_C(fc)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: remaining cycles to DONE plus the pending result
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_out = '0;
   logic         m_dbz = 1'b0;
   logic         m_z = 1'b0;
   logic         m_c = 1'b0;
   int           m_left = 0;
   logic [W-1:0] p_res;
   logic         p_dbz;
   logic         p_c;

   always @(posedge clk) begin : model
      bit acc;
      int prod;
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_out  = '0;
         m_dbz  = 1'b0;
         m_z    = 1'b0;
         m_c    = 1'b0;
         m_left = 0;
      end else begin
         acc    = start && (!m_busy || m_done);
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_out  = p_res;
               m_dbz  = p_dbz;
               m_z    = (p_res == 0);
               m_c    = p_c;
            end
         end
         if (acc) begin
            p_dbz = 1'b0;
            case (opcode)
               2'd0: begin
                  prod   = int'(a) + int'(b);
                  p_res  = prod[W-1:0];
                  p_c    = prod > 255;
                  m_left = 1;
               end
               2'd1: begin
                  p_res  = a - b;
                  p_c    = a < b;
                  m_left = 1;
               end
               2'd2: begin
                  prod   = int'(a) * int'(b);
                  p_res  = prod[W-1:0];
                  p_c    = prod > 255;
                  m_left = W + 1;
               end
               default: begin
                  p_c = 1'b0;
                  if (b == 0) begin
                     p_res  = '1;
                     p_dbz  = 1'b1;
                     m_left = 1;
                  end else begin
                     p_res  = a / b;
                     m_left = W + 1;
                  end
               end
            endcase
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_out  = p_res;
               m_dbz  = p_dbz;
               m_z    = (p_res == 0);
               m_c    = p_c;
            end
         end
         m_busy = m_done || (m_left > 0);
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) n_done++;
      if (cmp_en) begin
         chk("cmp_busy", 32'(busy), 32'(m_busy));
         chk("cmp_done", 32'(done), 32'(m_done));
         chk("cmp_out", 32'(dout), 32'(m_out));
         chk("cmp_dbz", 32'(dbz), 32'(m_dbz));
`ifdef ZEPHYR_ALU_FLAGS_EN
         chk("cmp_fz", 32'(fz), 32'(m_z));
         chk("cmp_fc", 32'(fc), 32'(m_c));
`endif
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Issue one op (optionally pulsing START again mid-op) and wait for DONE
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input int exp_l,
                         input logic [W-1:0] exp_out, input logic exp_dbz,
                         input logic exp_z, input logic exp_c,
                         input int pulse_at, input string nm);
      int n;
      start  = 1'b1;
      opcode = op;
      a      = av;
      b      = bv;
      @(posedge clk);
      #2;
      start  = 1'b0;
      a      = W'($urandom);
      b      = W'($urandom);
      opcode = 2'($urandom);
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         if (n == pulse_at) begin
            start  = 1'b1;
            opcode = 2'd0;
            a      = 8'd1;
            b      = 8'd1;
         end
         @(posedge clk);
         #2;
         start = 1'b0;
         n++;
      end
      chk({nm, "_lat"}, 32'(n), 32'(exp_l));
      chk({nm, "_out"}, 32'(dout), 32'(exp_out));
      chk({nm, "_dbz"}, 32'(dbz), 32'(exp_dbz));
`ifdef ZEPHYR_ALU_FLAGS_EN
      chk({nm, "_fz"}, 32'(fz), 32'(exp_z));
      chk({nm, "_fc"}, 32'(fc), 32'(exp_c));
`else
      if (exp_z === 1'bx || exp_c === 1'bx) $display("note: flag x");
`endif
   endtask

   initial begin
      int d0;
      rst    = 1'b1;
      start  = 1'b0;
      opcode = 2'd0;
      a      = '0;
      b      = '0;
      @(posedge clk);
      #2;
      cmp_en = 1'b1;
      idle(2);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out", 32'(dout), 32'd0);
      chk("rst_dbz", 32'(dbz), 32'd0);
      start = 1'b1;
      idle(1);
      chk("rst_over_start", 32'(busy), 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      idle(2);

      run_op(2'd0, 8'd200, 8'd100, 1, 8'd44, 1'b0, 1'b0, 1'b1, 0, "add");
      idle(2);
      run_op(2'd1, 8'd5, 8'd7, 1, 8'd254, 1'b0, 1'b0, 1'b1, 0, "sub_wrap");
      idle(1);
      run_op(2'd1, 8'd9, 8'd9, 1, 8'd0, 1'b0, 1'b1, 1'b0, 0, "sub_zero");
      idle(1);

      d0 = n_done;
      run_op(2'd2, 8'd20, 8'd13, 9, 8'd4, 1'b0, 1'b0, 1'b1, 3, "mul");
      idle(3);
      chk("mul_single_done", 32'(n_done - d0), 32'd1);

      run_op(2'd3, 8'd100, 8'd7, 9, 8'd14, 1'b0, 1'b0, 1'b0, 0, "div");
      idle(1);
      run_op(2'd3, 8'd100, 8'd0, 1, 8'd255, 1'b1, 1'b0, 1'b0, 0, "div0");
      run_op(2'd0, 8'd10, 8'd20, 1, 8'd30, 1'b0, 1'b0, 1'b0, 0, "b2b_add1");
      run_op(2'd0, 8'd250, 8'd10, 1, 8'd4, 1'b0, 1'b0, 1'b1, 0, "b2b_add2");
      run_op(2'd1, 8'd0, 8'd1, 1, 8'd255, 1'b0, 1'b0, 1'b1, 0, "b2b_sub");
      idle(2);

      run_op(2'd2, 8'd255, 8'd255, 9, 8'd1, 1'b0, 1'b0, 1'b1, 0, "mul_max");
      run_op(2'd3, 8'd255, 8'd1, 9, 8'd255, 1'b0, 1'b0, 1'b0, 0, "div_one");
      run_op(2'd3, 8'd7, 8'd100, 9, 8'd0, 1'b0, 1'b1, 1'b0, 0, "div_small");
      idle(2);

      start  = 1'b1;
      opcode = 2'd2;
      a      = 8'd20;
      b      = 8'd13;
      @(posedge clk);
      #2;
      start = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_out", 32'(dout), 32'd0);
      d0 = n_done;
      idle(12);
      chk("abort_no_done", 32'(n_done - d0), 32'd0);
      run_op(2'd0, 8'd3, 8'd4, 1, 8'd7, 1'b0, 1'b0, 1'b0, 0, "add_after");
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
